// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill engine feeding the framebuffer write port.
// Takes one rectangle command (two corners plus colour), normalises and clips
// it to the visible area, then walks it in raster order.
// Each accepted cycle (we_o & pix_ready_i) produces one pixel write.
// All outputs come straight from registers.
module vga_rect_fill #(
  parameter int COORD_W = 11,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COORD_W-1:0] cmd_x0_i,
  input  logic [COORD_W-1:0] cmd_y0_i,
  input  logic [COORD_W-1:0] cmd_x1_i,
  input  logic [COORD_W-1:0] cmd_y1_i,
  input  logic               cmd_color_i,
  input  logic               abort_i,
  input  logic               pix_ready_i,
  output logic [COORD_W-1:0] addr_x_o,
  output logic [COORD_W-1:0] addr_y_o,
  output logic               color_o,
  output logic               we_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Last visible column/row. Coordinates above these are off-screen.
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] COORD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};

  state_e             state_q, state_d;

  // Raw command, latched at accept
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] y0_q, y0_d;
  logic [COORD_W-1:0] x1_q, x1_d;
  logic [COORD_W-1:0] y1_q, y1_d;
  logic               color_q, color_d;

  // Normalised and clipped bounds, loaded in SETUP
  logic [COORD_W-1:0] xmin_q, xmin_d;
  logic [COORD_W-1:0] xmax_q, xmax_d;
  logic [COORD_W-1:0] ymax_q, ymax_d;

  // Raster walk position
  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;

  // Registered output flags, computed from the next state
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // SETUP helpers: corner ordering, clipping and empty detection
  logic [COORD_W-1:0] norm_xmin_s;
  logic [COORD_W-1:0] norm_xmax_s;
  logic [COORD_W-1:0] norm_ymin_s;
  logic [COORD_W-1:0] norm_ymax_s;
  logic [COORD_W-1:0] clip_xmax_s;
  logic [COORD_W-1:0] clip_ymax_s;
  logic               empty_s;

  // Order the latched corners and clip the far edges to the visible area
  always_comb begin
    norm_xmin_s = x0_q;
    norm_xmax_s = x1_q;
    norm_ymin_s = y0_q;
    norm_ymax_s = y1_q;
    if (x1_q < x0_q) begin
      norm_xmin_s = x1_q;
      norm_xmax_s = x0_q;
    end else begin
      norm_xmin_s = x0_q;
      norm_xmax_s = x1_q;
    end
    if (y1_q < y0_q) begin
      norm_ymin_s = y1_q;
      norm_ymax_s = y0_q;
    end else begin
      norm_ymin_s = y0_q;
      norm_ymax_s = y1_q;
    end
    if (norm_xmax_s > X_LAST) begin
      clip_xmax_s = X_LAST;
    end else begin
      clip_xmax_s = norm_xmax_s;
    end
    if (norm_ymax_s > Y_LAST) begin
      clip_ymax_s = Y_LAST;
    end else begin
      clip_ymax_s = norm_ymax_s;
    end
    // A near corner that is already off-screen leaves nothing to draw.
    // Otherwise the clipped far edge cannot fall below the near edge.
    empty_s = (norm_xmin_s > X_LAST) || (norm_ymin_s > Y_LAST);
  end

  // Next-state logic: command accept, setup, raster walk and the done pulse
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    cx_d    = cx_q;
    cy_d    = cy_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          x0_d    = cmd_x0_i;
          y0_d    = cmd_y0_i;
          x1_d    = cmd_x1_i;
          y1_d    = cmd_y1_i;
          color_d = cmd_color_i;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (abort_i) begin
          state_d = S_DONE;
        end else if (empty_s) begin
          state_d = S_DONE;
        end else begin
          xmin_d  = norm_xmin_s;
          xmax_d  = clip_xmax_s;
          ymax_d  = clip_ymax_s;
          cx_d    = norm_xmin_s;
          cy_d    = norm_ymin_s;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Abort wins over a same-cycle accepted write. That write does not
        // count, so the position is left where it was.
        if (abort_i) begin
          state_d = S_DONE;
        end else if (pix_ready_i) begin
          if (cx_q == xmax_q) begin
            if (cy_q == ymax_q) begin
              state_d = S_DONE;
            end else begin
              cx_d = xmin_q;
              cy_d = cy_q + COORD_ONE;
            end
          end else begin
            cx_d = cx_q + COORD_ONE;
          end
        end else begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags follow the state the engine is about to enter, so they are registered
  always_comb begin
    ready_d = (state_d == S_IDLE);
    we_d    = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, command, bounds, position and output flag registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      x0_q    <= COORD_ZERO;
      y0_q    <= COORD_ZERO;
      x1_q    <= COORD_ZERO;
      y1_q    <= COORD_ZERO;
      color_q <= 1'b0;
      xmin_q  <= COORD_ZERO;
      xmax_q  <= COORD_ZERO;
      ymax_q  <= COORD_ZERO;
      cx_q    <= COORD_ZERO;
      cy_q    <= COORD_ZERO;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign addr_x_o    = cx_q;
  assign addr_y_o    = cy_q;
  assign color_o     = color_q;
  assign we_o        = we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed and randomised rectangle commands.
// Each command's expected pixel list comes from a simple loop model over the
// clipped, normalised rectangle. The model is compared against every write
// the DUT presents.
module tb_vga_rect_fill;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [CW-1:0] cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i;
  logic          cmd_color_i;
  logic          abort_i;
  logic          pix_ready_i;
  logic [CW-1:0] addr_x_o, addr_y_o;
  logic          color_o, we_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;
  int ex_q[$];
  int ey_q[$];

  always #5 clk = ~clk;

  vga_rect_fill #(.COORD_W(CW), .H_RES(640), .V_RES(480)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i),
    .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
    .cmd_color_i(cmd_color_i), .abort_i(abort_i), .pix_ready_i(pix_ready_i),
    .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .color_o(color_o),
    .we_o(we_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: every pixel of the inclusive, clipped rectangle in raster order
  task automatic build_model(input int x0, input int y0, input int x1, input int y1);
    int xlo, xhi, ylo, yhi;
    ex_q.delete();
    ey_q.delete();
    xlo = (x0 < x1) ? x0 : x1;
    xhi = (x0 < x1) ? x1 : x0;
    ylo = (y0 < y1) ? y0 : y1;
    yhi = (y0 < y1) ? y1 : y0;
    if (xhi > 639) xhi = 639;
    if (yhi > 479) yhi = 479;
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        ex_q.push_back(x);
        ey_q.push_back(y);
      end
    end
  endtask

  // mode: 0 ready always, 1 ready toggling 1,0,..., 2 random ready
  // abort_at: abort when this many writes are done (-1 = never)
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input bit col, input int mode, input int abort_at,
                         input bit abort_setup, input bit busy_cmd);
    int  writes;
    int  run_cyc;
    int  budget;
    bit  aborted;
    bit  pr;
    writes  = 0;
    run_cyc = 0;
    aborted = 1'b0;
    build_model(x0, y0, x1, y1);
    budget = 4 * ex_q.size() + 20;

    @(negedge clk);
    check("idle_ready", int'(cmd_ready_o), 1);
    check("idle_busy", int'(busy_o), 0);
    cmd_valid_i = 1'b1;
    cmd_x0_i = CW'(x0);
    cmd_y0_i = CW'(y0);
    cmd_x1_i = CW'(x1);
    cmd_y1_i = CW'(y1);
    cmd_color_i = col;

    @(negedge clk);
    check("setup_busy", int'(busy_o), 1);
    check("setup_ready", int'(cmd_ready_o), 0);
    check("setup_we", int'(we_o), 0);
    if (busy_cmd) begin
      // A different command held while busy must not be taken
      cmd_x0_i = CW'(100);
      cmd_y0_i = CW'(100);
      cmd_x1_i = CW'(120);
      cmd_y1_i = CW'(130);
      cmd_color_i = ~col;
    end else begin
      cmd_valid_i = 1'b0;
    end
    abort_i = abort_setup;
    if (abort_setup) aborted = 1'b1;

    while (1) begin
      @(negedge clk);
      abort_i = 1'b0;
      pix_ready_i = 1'b0;
      if (!aborted && ex_q.size() > 0) begin
        check("run_we", int'(we_o), 1);
        check("run_x", int'(addr_x_o), ex_q[0]);
        check("run_y", int'(addr_y_o), ey_q[0]);
        check("run_color", int'(color_o), int'(col));
        check("run_done", int'(done_o), 0);
        if (mode == 0) pr = 1'b1;
        else if (mode == 1) pr = (run_cyc % 2 == 0);
        else pr = 1'($urandom_range(0, 1));
        run_cyc++;
        pix_ready_i = pr;
        if (writes == abort_at) begin
          abort_i = 1'b1;
          aborted = 1'b1;
        end else if (pr) begin
          void'(ex_q.pop_front());
          void'(ey_q.pop_front());
          writes++;
        end
      end else begin
        check("done_pulse", int'(done_o), 1);
        check("done_we", int'(we_o), 0);
        check("done_busy", int'(busy_o), 1);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("post_ready", int'(cmd_ready_o), 1);
        check("post_busy", int'(busy_o), 0);
        check("post_done", int'(done_o), 0);
        check("post_we", int'(we_o), 0);
        break;
      end
      budget--;
      if (budget == 0) begin
        check("timeout", 0, 1);
        cmd_valid_i = 1'b0;
        break;
      end
    end
  endtask

  function automatic int rand_coord(input int lo_edge, input int hi_edge);
    int sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: return int'($urandom_range(0, 10));
      1: return int'($urandom_range(lo_edge, hi_edge));
      2: return int'($urandom_range(2040, 2047));
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  function automatic int near(input int base);
    int v;
    v = base + int'($urandom_range(0, 12)) - 6;
    if (v < 0) v = 0;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  initial begin
    int x0, y0, x1, y1;
    rstn_i = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_x0_i = '0; cmd_y0_i = '0; cmd_x1_i = '0; cmd_y1_i = '0;
    cmd_color_i = 1'b0;
    abort_i = 1'b0;
    pix_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(cmd_ready_o), 1);
    check("rst_we", int'(we_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_x", int'(addr_x_o), 0);
    check("rst_y", int'(addr_y_o), 0);
    check("rst_color", int'(color_o), 0);
    rstn_i = 1'b1;

    // Basic 3x2 fill, then the same with swapped corners
    run_cmd(2, 3, 4, 4, 1'b1, 0, -1, 1'b0, 1'b0);
    run_cmd(4, 4, 2, 3, 1'b1, 0, -1, 1'b0, 1'b0);
    // Clipping at the bottom-right corner and a fully off-screen fill
    run_cmd(638, 478, 700, 500, 1'b0, 0, -1, 1'b0, 1'b0);
    run_cmd(650, 10, 700, 20, 1'b1, 0, -1, 1'b0, 1'b0);
    // Backpressure with toggling ready
    run_cmd(2, 3, 4, 4, 1'b1, 1, -1, 1'b0, 1'b0);
    // Abort on the 15th write of a 10x10 fill, and abort during setup
    run_cmd(0, 0, 9, 9, 1'b1, 0, 14, 1'b0, 1'b0);
    run_cmd(0, 0, 9, 9, 1'b0, 0, -1, 1'b1, 1'b0);
    // Single pixel; a command held valid while busy is ignored
    run_cmd(5, 5, 5, 5, 1'b1, 0, -1, 1'b0, 1'b0);
    run_cmd(7, 1, 3, 2, 1'b0, 2, -1, 1'b0, 1'b1);

    // Randomised commands near the origin, the clip edges and the coordinate limit
    for (int n = 0; n < 30; n++) begin
      x0 = rand_coord(630, 645);
      y0 = rand_coord(470, 485);
      x1 = near(x0);
      y1 = near(y0);
      run_cmd(x0, y0, x1, y1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1,
              1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a fill: write strobe drops at once, no done pulse
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_x0_i = CW'(0); cmd_y0_i = CW'(0); cmd_x1_i = CW'(9); cmd_y1_i = CW'(9);
    cmd_color_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    pix_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_we_before", int'(we_o), 1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("mid_rst_we", int'(we_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_ready", int'(cmd_ready_o), 1);
    check("mid_rst_done", int'(done_o), 0);
    pix_ready_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_done", int'(done_o), 0);
      check("after_rst_busy", int'(busy_o), 0);
    end
    // Engine still works after the mid-fill reset
    run_cmd(5, 5, 5, 5, 1'b0, 0, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
